// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 Gaussian convolution: kernel weights,
// normalisation shift and a default pixel type.
package conv_pkg;
   localparam int PIX_W      = 8;
   localparam int K_CORNER   = 1;
   localparam int K_EDGE     = 2;
   localparam int K_CENTER   = 4;
   localparam int NORM_SHIFT = 4;

   typedef logic [PIX_W-1:0] pixel_t;

   // Weight at window position (r, c); row/column index 1 is the center line.
   function automatic int coef(input int r, input int c);
      if (r == 1 && c == 1)      return K_CENTER;
      else if (r == 1 || c == 1) return K_EDGE;
      else                       return K_CORNER;
   endfunction
endpackage

// File: rtl/line_buffer.sv
// Resettable circular delay line: dout is din delayed by DEPTH samples.
module line_buffer
   import conv_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int DEPTH     = 540
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] din,
   output logic [WORD_SIZE-1:0] dout
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_SIZE-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     ptr;

   // The slot about to be overwritten holds the sample from DEPTH edges ago.
   assign dout = mem[ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         ptr <= '0;
      end else begin
         mem[ptr] <= din;
         ptr      <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
      end
   end
endmodule

// File: rtl/convolution.sv
// Streaming 3x3 Gaussian filter over a raster pixel stream, one sample per clock,
// latency ROW_SIZE+2 from a pixel to its filtered value.
module convolution
   import conv_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE  = 540
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WORD_SIZE-1:0] inputPixel,
   output logic [WORD_SIZE-1:0] outputPixel
);
   localparam int SUM_W = WORD_SIZE + 4;

   logic [WORD_SIZE-1:0]            lb1_out, lb2_out;
   logic [WORD_SIZE-1:0]            head [3];
   logic [2:0][WORD_SIZE-1:0]       win  [3];
   logic [SUM_W-1:0]                acc;

   line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(ROW_SIZE)) u_lb1 (
      .clk (clk), .rst (rst), .din (inputPixel), .dout (lb1_out)
   );

   line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(ROW_SIZE)) u_lb2 (
      .clk (clk), .rst (rst), .din (lb1_out), .dout (lb2_out)
   );

   assign head[0] = inputPixel;
   assign head[1] = lb1_out;
   assign head[2] = lb2_out;

   // Weights sum to 16, so acc >> 4 always fits in WORD_SIZE bits.
   always_comb begin
      acc = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            acc = acc + SUM_W'(win[r][c]) * SUM_W'(coef(r, c));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++) win[r] <= '0;
         outputPixel <= '0;
      end else begin
         for (int r = 0; r < 3; r++) win[r] <= {win[r][1:0], head[r]};
         outputPixel <= WORD_SIZE'(acc >> NORM_SHIFT);
      end
   end
endmodule

// File: tb/tb_convolution.sv
// Directed and random checks of convolution (ROW_SIZE=8) against an image-level model.
module tb_convolution;
   import conv_pkg::*;

   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] inputPixel = 8'h00;
   logic [7:0] outputPixel;

   int total = 0;
   int bad   = 0;
   int hist[$];

   convolution #(.WORD_SIZE(8), .ROW_SIZE(D)) dut (
      .clk (clk), .rst (rst), .inputPixel (inputPixel), .outputPixel (outputPixel)
   );

   always #5 clk = ~clk;

   // Sample k (1-based since reset); anything before the stream started is 0.
   function automatic int pix(input int k);
      if (k >= 1 && k <= hist.size()) return hist[k-1];
      return 0;
   endfunction

   // Expected output after the n-th streaming edge: Gaussian centred on
   // sample n-D-2, neighbours one row (D samples) or one column apart.
   function automatic logic [7:0] model(input int n);
      int c, s;
      c = n - D - 2;
      s = 0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            s += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * pix(c + dr * D + dc);
      return 8'(s / 16);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rst_step(input logic [7:0] p);
      rst = 1'b1;
      inputPixel = p;
      @(posedge clk);
      hist.delete();
      @(negedge clk);
      chk("reset", outputPixel, 8'h00);
   endtask

   task automatic step(input logic [7:0] p, input string tag);
      rst = 1'b0;
      inputPixel = p;
      @(posedge clk);
      hist.push_back(int'(p));
      @(negedge clk);
      chk(tag, outputPixel, model(hist.size()));
   endtask

   initial begin
      int p;
      @(negedge clk);

      // Reset held two cycles with a nonzero input, then the first free edge.
      rst_step(8'hAA);
      rst_step(8'hAA);
      step(8'hAA, "first_after_reset");

      // Flat field ramps up, then settles exactly on the input.
      rst_step(8'h00);
      for (int i = 1; i <= 3 * D + 6; i++) begin
         step(8'h40, "flat_model");
         if (i >= 2 * D + 4) chk("flat_steady", outputPixel, 8'h40);
      end

      // Full scale must not overflow.
      rst_step(8'h00);
      for (int i = 1; i <= 3 * D + 6; i++) begin
         step(8'hFF, "full_model");
         if (i >= 2 * D + 4) chk("full_steady", outputPixel, 8'hFF);
      end

      // Impulse response at the expected offsets.
      rst_step(8'h00);
      p = 2 * D + 5;
      for (int i = 1; i <= 4 * D + 10; i++) begin
         step((i == p) ? 8'hFF : 8'h00, "impulse_model");
         if (i == p + D + 2)     chk("imp_center", outputPixel, 8'h3F);
         if (i == p + D + 1)     chk("imp_left",   outputPixel, 8'h1F);
         if (i == p + D + 3)     chk("imp_right",  outputPixel, 8'h1F);
         if (i == p + 2)         chk("imp_up",     outputPixel, 8'h1F);
         if (i == p + 2 * D + 2) chk("imp_down",   outputPixel, 8'h1F);
         if (i == p + 2 * D + 3) chk("imp_diag",   outputPixel, 8'h0F);
         if (i == p + 1)         chk("imp_diag_up", outputPixel, 8'h0F);
      end

      // Mid-stream reset wipes all history.
      rst_step(8'h00);
      for (int i = 0; i < 20; i++) step(8'h80, "pre_reset_model");
      rst_step(8'h80);
      for (int i = 0; i < 3 * D + 6; i++) begin
         step(8'h00, "post_reset_model");
         chk("post_reset_zero", outputPixel, 8'h00);
      end

      // Random stream across many row wraps.
      rst_step(8'h00);
      for (int i = 0; i < 300; i++) step(8'($urandom_range(0, 255)), "random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/convolution.md
CONVOLUTION -- requirements
Module: convolution

Interface
REQ-001 Parameter WORD_SIZE, default 8, bit width of input and output pixels.
REQ-002 Parameter ROW_SIZE, default 540, image row length in pixels (line-buffer depth).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 inputPixel  input  WORD_SIZE  unsigned pixel sample, raster order, one sample per clock.
REQ-006 outputPixel  output  WORD_SIZE  unsigned filtered pixel, registered.

Function
REQ-007 The block SHALL sample inputPixel on every rising clk edge while rst is low; there is no valid/ready handshake, so a value held N cycles counts as N samples.
REQ-008 The block SHALL keep two line buffers of ROW_SIZE entries each, cascaded, giving the samples delayed by ROW_SIZE and 2*ROW_SIZE cycles.
REQ-009 The block SHALL form a 3x3 window from the 3 newest samples of each stream: the direct input, the ROW_SIZE-delayed stream and the 2*ROW_SIZE-delayed stream.
REQ-010 The window center SHALL be the sample taken ROW_SIZE+1 cycles before the newest window sample.
REQ-011 The kernel SHALL be the fixed Gaussian [1 2 1; 2 4 2; 1 2 1].
- Products are summed at full width, WORD_SIZE+4 bits minimum.
- The sum is then shifted right by 4 (truncate, divide by 16).
REQ-012 The result SHALL never exceed 2^WORD_SIZE-1 because the weights sum to 16; no saturation logic is required.
REQ-013 outputPixel SHALL be registered, one pipeline stage after the window registers.
REQ-014 Total latency SHALL be ROW_SIZE+2 rising edges from sampling a pixel to that pixel appearing on outputPixel as the window center.
REQ-015 Boundaries: there is no edge padding or row-wrap masking.
- Windows straddling row ends combine pixels from adjacent rows.
- During the first 2*ROW_SIZE+2 cycles after reset, not-yet-filled window positions contribute 0.
REQ-016 Line-buffer addressing SHALL wrap modulo ROW_SIZE with no gap cycle at wrap-around.

Reset
REQ-017 When rst is high at a rising edge, the following SHALL clear to 0: all window registers, all line-buffer contents, line-buffer pointers and outputPixel.
REQ-018 Reset asserted mid-stream SHALL discard all history; output SHALL then follow REQ-015 as if streaming started fresh at the first edge with rst low.
REQ-019 Clearing line-buffer contents within one cycle is required, so storage SHALL be flops or an equivalent resettable structure, not uninitialised RAM.

Structure
REQ-020 A shared package conv_pkg SHALL hold the kernel coefficient constants, the normalisation shift (4) and a pixel typedef sized by WORD_SIZE.
REQ-021 One sub-module line_buffer SHALL be used, parameterised by WORD_SIZE and DEPTH, with ports clk, rst, din, dout and DEPTH cycles of delay; it is instantiated twice.
REQ-022 Target implementation size is 120-400 lines of RTL total.

Verification
Directed tests use ROW_SIZE=8, WORD_SIZE=8 unless noted.
REQ-023 Reset: hold rst for 2 cycles with inputPixel=0xAA -> outputPixel=0x00 during reset and on the first edge after release.
REQ-024 Flat field: stream constant 0x40 -> outputPixel=0x00 initially, ramping up, then exactly 0x40 from edge 2*ROW_SIZE+4 onward.
REQ-025 Full scale: stream constant 0xFF -> steady-state outputPixel=0xFF with no overflow or wrap.
REQ-026 Impulse: single 0xFF sample in a field of 0x00 -> responses below appear at the offsets of REQ-014, all other outputs 0x00.
- Center response 0x3F.
- Edge-neighbour responses (horizontally or vertically adjacent to the impulse) 0x1F.
- Diagonal-neighbour responses 0x0F.
REQ-027 Mid-stream reset: after 20 cycles of 0x80, assert rst 1 cycle, then stream 0x00 -> outputPixel=0x00 for every subsequent cycle, with no residue from the 0x80 history.
REQ-028 Default parameters: stream a 360x540 frame, each pixel held 2 cycles -> no X on outputPixel after reset; flat regions reproduce the input value.
